baud_tick_gen: RTL and testbench
================================

# baud_tick_gen

- Parametrised fractional baud-rate tick generator for the UART.
- Produces three single-cycle strobes from one programmable divisor:
  - an oversampling tick;
  - a mid-bit sample tick;
  - a bit-boundary tick.
- Sits between the register file (divisor/OSR configuration) and the UART TX/RX engines.
- Supports fractional divisors and receiver phase re-alignment on start-bit detection.

## Interface

- DIV_W, 16: width of integer divisor.
- FRAC_W, 4: width of fractional divisor; fractional step is 1/2^FRAC_W.
- OSR_W, 5: width of oversampling-ratio field.

- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- enable  in  1  count enable; low freezes all state and suppresses ticks
- resync  in  1  synchronous phase restart (RX start-bit edge)
- div_int  in  DIV_W  integer clocks per oversample tick; 0 is illegal
- div_frac  in  FRAC_W  fractional clocks per oversample tick, in units of 2^-FRAC_W
- osr  in  OSR_W  oversample ticks per bit minus one (15 = 16x)
- os_tick  out  1  registered 1-cycle oversample strobe
- mid_tick  out  1  registered 1-cycle strobe at bit centre
- bit_tick  out  1  registered 1-cycle strobe at end of bit
- cfg_err  out  1  registered; high while div_int == 0

## Operation

**State**
- presc (DIV_W+1 bits)
- acc (FRAC_W bits)
- stretch (1 bit)
- os_cnt (OSR_W bits)

**Reset**
- All state and all outputs reset to 0.

**Priority per edge:** reset > cfg_err > resync > enable.

**cfg_err**
- cfg_err <= (div_int == 0).
- While div_int == 0: presc, acc, stretch and os_cnt are cleared, and no tick asserts.

**resync = 1**
- presc, acc, stretch and os_cnt are cleared.
- All ticks are 0 next cycle, regardless of enable.

**enable = 0**
- State holds and all ticks are 0.

**enable = 1: prescaler**
- terminal = div_int - 1 + stretch.
- If presc >= terminal:
  - presc <= 0;
  - os_tick <= 1;
  - {stretch, acc} <= acc + div_frac (FRAC_W+1-bit sum; the carry becomes stretch for the next period).
- Otherwise presc <= presc + 1.
- The >= compare guarantees an immediate wrap when div_int shrinks below the current count.

**enable = 1: oversample counter** (on each os_tick event)
- If os_cnt >= osr: os_cnt <= 0 and bit_tick <= 1.
- Otherwise os_cnt <= os_cnt + 1.
- mid_tick <= 1 when os_cnt == (osr >> 1) at that event.

**Tick widths**
- Ticks not generated on an edge are driven 0; every tick is exactly one cycle wide.

**Average period**
- os_tick average period = div_int + div_frac/2^FRAC_W cycles.
- bit_tick period = (osr+1) os_tick periods.

**Special cases**
- osr == 0: os_tick, mid_tick and bit_tick coincide on every event.
- div_int == 1 with div_frac == 0: os_tick is continuously high.

**Configuration changes**
- Configuration inputs are used live each cycle; no shadowing.
- Software changes them only while enable = 0 or is tolerant of one irregular period.

## Timing

**Tick latency**
- All ticks are registered.
- A tick decided on edge k is high during the cycle after edge k.

**After reset release** (enable=1, div_frac=0)
- First os_tick appears after the div_int-th enabled edge.
- Subsequent os_ticks are div_int cycles apart.
- First mid_tick coincides with os_tick number (osr>>1)+1.
- First bit_tick coincides with os_tick number osr+1.

**resync**
- resync asserted on edge k: the first os_tick after it follows exactly div_int enabled edges later, counted from edge k+1.
- A resync coincident with a would-be tick suppresses that tick.

**enable low**
- Enable low for M cycles delays all subsequent ticks by exactly M cycles, with no phase loss.

**cfg_err**
- Asserts/deasserts one cycle after div_int changes to/from 0.
- After clearing, the counters restart from 0 (same as post-reset).

**Reset mid-period**
- Reset asserted mid-period clears outputs immediately (asynchronous), with no glitch pulse on deassertion.

## Test plan

- **Integer divide:** div_int=4, div_frac=0, osr=3, enable=1 after reset → os_tick at edges 4,8,12,16…; mid_tick at edge 8; bit_tick at edges 16,32.
- **Fractional divide:** div_int=4, div_frac=8 (FRAC_W=4), osr=15.
  - Interval sequence 4,4,5,4,5…;
  - os_tick #1 to #33 spans exactly 144 cycles;
  - bit_tick every 72 cycles after the first.
- **Resync:** div_int=10, osr=15; pulse resync mid-bit (os_cnt=5, presc=3).
  - No tick that cycle;
  - next os_tick 10 cycles later;
  - mid_tick on 8th os_tick and bit_tick on 16th os_tick after resync.
- **Enable gating:** div_int=6; drop enable for 7 cycles mid-period → no ticks while low; all later ticks shifted by exactly 7 cycles.
- **Illegal divisor:** div_int=0.
  - cfg_err=1 next cycle, zero ticks over 100 cycles;
  - restore div_int=3: cfg_err=0 and first os_tick 3 enabled edges after the clear.
- **Divisor shrink and reset:**
  - presc=20 with div_int changed from 50 to 8 → os_tick on next edge, then every 8;
  - assert reset_n low mid-period → all outputs 0 immediately; ticks restart cleanly after release.

Source files
------------

// File: rtl/baud_tick_gen.sv
// Fractional baud-rate tick generator: oversample, mid-bit and bit-end
// strobes derived from one integer+fraction divisor and an oversample ratio.
module baud_tick_gen #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OSR_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              resync,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic [OSR_W-1:0]  osr,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              cfg_err
);

    logic [DIV_W:0]   presc_q, presc_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic             stretch_q, stretch_d;
    logic [OSR_W-1:0] os_cnt_q, os_cnt_d;
    logic             os_q, os_d;
    logic             mid_q, mid_d;
    logic             bit_q, bit_d;
    logic             err_q, err_d;

    logic             div_zero;
    logic [DIV_W:0]   terminal;
    logic [FRAC_W:0]  acc_sum;
    logic             wrap;

    assign div_zero = (div_int == '0);

    // A carry out of the fraction stretches the following period by one clock.
    assign terminal = {1'b0, div_int} - (DIV_W+1)'(1)
                    + (DIV_W+1)'(stretch_q);
    assign acc_sum  = {1'b0, acc_q} + {1'b0, div_frac};

    // >= lets a shrunk divisor wrap at once instead of counting past it.
    assign wrap = (presc_q >= terminal);

    always_comb begin
        presc_d   = presc_q;
        acc_d     = acc_q;
        stretch_d = stretch_q;
        os_cnt_d  = os_cnt_q;
        os_d      = 1'b0;
        mid_d     = 1'b0;
        bit_d     = 1'b0;
        err_d     = div_zero;

        if (div_zero || resync) begin
            presc_d   = '0;
            acc_d     = '0;
            stretch_d = 1'b0;
            os_cnt_d  = '0;
        end else if (enable) begin
            if (wrap) begin
                presc_d   = '0;
                os_d      = 1'b1;
                acc_d     = acc_sum[FRAC_W-1:0];
                stretch_d = acc_sum[FRAC_W];
                mid_d     = (os_cnt_q == (osr >> 1));
                if (os_cnt_q >= osr) begin
                    os_cnt_d = '0;
                    bit_d    = 1'b1;
                end else begin
                    os_cnt_d = os_cnt_q + OSR_W'(1);
                end
            end else begin
                presc_d = presc_q + (DIV_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= '0;
            acc_q     <= '0;
            stretch_q <= 1'b0;
            os_cnt_q  <= '0;
            os_q      <= 1'b0;
            mid_q     <= 1'b0;
            bit_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            acc_q     <= acc_d;
            stretch_q <= stretch_d;
            os_cnt_q  <= os_cnt_d;
            os_q      <= os_d;
            mid_q     <= mid_d;
            bit_q     <= bit_d;
            err_q     <= err_d;
        end
    end

    assign os_tick  = os_q;
    assign mid_tick = mid_q;
    assign bit_tick = bit_q;
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: directed timing scenarios plus randomized
// traffic checked against a closed-form tick-schedule model.
module tb_baud_tick_gen;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OSR_W  = 5;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic              resync = 1'b0;
    logic [DIV_W-1:0]  div_int = 16'd4;
    logic [FRAC_W-1:0] div_frac = '0;
    logic [OSR_W-1:0]  osr = '0;
    logic              os_tick, mid_tick, bit_tick, cfg_err;

    int n_pass = 0;
    int n_total = 0;

    baud_tick_gen #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR_W(OSR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .resync(resync),
        .div_int(div_int), .div_frac(div_frac), .osr(osr),
        .os_tick(os_tick), .mid_tick(mid_tick), .bit_tick(bit_tick),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Model: tick n (1-based) after a clear lands on enabled edge
    // n*div + floor((n-1)*frac / 2^FRAC_W).
    longint k, nx;
    logic e_os, e_mid, e_bit, e_err;

    function automatic longint t_of(longint n, longint d, longint f);
        return n * d + (((n - 1) * f) >> FRAC_W);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k = 0; nx = 1;
            e_os = 0; e_mid = 0; e_bit = 0; e_err = 0;
        end else begin
            e_err = (div_int == 0);
            e_os = 0; e_mid = 0; e_bit = 0;
            if (div_int == 0 || resync) begin
                k = 0; nx = 1;
            end else if (enable) begin
                k++;
                if (k == t_of(nx, longint'(div_int), longint'(div_frac))) begin
                    e_os  = 1;
                    e_mid = ((nx - 1) % (longint'(osr) + 1)) == longint'(osr >> 1);
                    e_bit = (nx % (longint'(osr) + 1)) == 0;
                    nx++;
                end
            end
        end
    end

    task automatic do_reset(input int d, input int f, input int o);
        @(negedge clk);
        reset_n = 1'b0;
        enable = 1'b1;
        resync = 1'b0;
        div_int = DIV_W'(d);
        div_frac = FRAC_W'(f);
        osr = OSR_W'(o);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_total++;
        if ({os_tick, mid_tick, bit_tick, cfg_err} !== 4'b0000) begin
            $display("FAIL reset_state got=%b want=0000",
                     {os_tick, mid_tick, bit_tick, cfg_err});
        end else n_pass++;
    endtask

    task automatic test_integer;
        logic [2:0] want;
        do_reset(4, 0, 3);
        for (int e = 1; e <= 34; e++) begin
            @(negedge clk);
            want = {e % 4 == 0, e == 8 || e == 24, e == 16 || e == 32};
            n_total++;
            if ({os_tick, mid_tick, bit_tick} !== want) begin
                $display("FAIL integer edge=%0d got=%b want=%b",
                         e, {os_tick, mid_tick, bit_tick}, want);
            end else n_pass++;
        end
    endtask

    task automatic test_fractional;
        int os_t[$];
        int bit_t[$];
        do_reset(4, 8, 15);
        for (int e = 1; e <= 230; e++) begin
            @(negedge clk);
            if (os_tick) os_t.push_back(e);
            if (bit_tick) bit_t.push_back(e);
        end
        n_total++;
        if (os_t.size() < 33 || bit_t.size() < 3) begin
            $display("FAIL frac_count os=%0d bit=%0d want>=33,>=3",
                     os_t.size(), bit_t.size());
        end else begin
            n_pass++;
            n_total++;
            if (os_t[1] - os_t[0] != 4 || os_t[2] - os_t[1] != 5
                || os_t[0] != 4) begin
                $display("FAIL frac_intervals got=%0d,%0d,%0d want=4,4,5",
                         os_t[0], os_t[1] - os_t[0], os_t[2] - os_t[1]);
            end else n_pass++;
            n_total++;
            if (os_t[32] - os_t[0] != 144) begin
                $display("FAIL frac_span33 got=%0d want=144",
                         os_t[32] - os_t[0]);
            end else n_pass++;
            n_total++;
            if (bit_t[1] - bit_t[0] != 72 || bit_t[2] - bit_t[1] != 72) begin
                $display("FAIL frac_bit_period got=%0d,%0d want=72,72",
                         bit_t[1] - bit_t[0], bit_t[2] - bit_t[1]);
            end else n_pass++;
        end
    endtask

    task automatic test_resync;
        int first_os, first_mid, first_bit;
        do_reset(10, 0, 15);
        repeat (53) @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        n_total++;
        if ({os_tick, mid_tick, bit_tick} !== 3'b000) begin
            $display("FAIL resync_quiet got=%b want=000",
                     {os_tick, mid_tick, bit_tick});
        end else n_pass++;
        first_os = -1; first_mid = -1; first_bit = -1;
        for (int r = 1; r <= 170; r++) begin
            @(negedge clk);
            if (os_tick && first_os < 0) first_os = r;
            if (mid_tick && first_mid < 0) first_mid = r;
            if (bit_tick && first_bit < 0) first_bit = r;
        end
        n_total++;
        if (first_os != 10 || first_mid != 80 || first_bit != 160) begin
            $display("FAIL resync_phase got=%0d/%0d/%0d want=10/80/160",
                     first_os, first_mid, first_bit);
        end else n_pass++;
        // resync landing on the edge that would have ticked
        do_reset(4, 0, 3);
        repeat (3) @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        n_total++;
        if (os_tick !== 1'b0) begin
            $display("FAIL resync_suppress got=%b want=0", os_tick);
        end else n_pass++;
    endtask

    task automatic test_enable;
        logic want;
        do_reset(6, 0, 3);
        for (int e = 1; e <= 30; e++) begin
            @(negedge clk);
            want = (e == 6 || e == 19 || e == 25);
            n_total++;
            if (os_tick !== want) begin
                $display("FAIL enable_gate edge=%0d got=%b want=%b",
                         e, os_tick, want);
            end else n_pass++;
            if (e == 8) enable = 1'b0;
            if (e == 15) enable = 1'b1;
        end
    endtask

    task automatic test_illegal;
        int ticks;
        do_reset(3, 0, 3);
        repeat (5) @(negedge clk);
        div_int = '0;
        @(negedge clk);
        n_total++;
        if (cfg_err !== 1'b1) begin
            $display("FAIL cfg_err_set got=%b want=1", cfg_err);
        end else n_pass++;
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ticks += int'(os_tick) + int'(mid_tick) + int'(bit_tick);
        end
        n_total++;
        if (ticks != 0 || cfg_err !== 1'b1) begin
            $display("FAIL cfg_err_quiet ticks=%0d err=%b want=0,1",
                     ticks, cfg_err);
        end else n_pass++;
        div_int = DIV_W'(3);
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            n_total++;
            if ({cfg_err, os_tick} !== {1'b0, e == 3 || e == 6}) begin
                $display("FAIL cfg_err_clear edge=%0d got=%b want=%b",
                         e, {cfg_err, os_tick}, {1'b0, e == 3 || e == 6});
            end else n_pass++;
        end
    endtask

    task automatic test_shrink_reset;
        do_reset(50, 0, 7);
        repeat (20) @(negedge clk);
        div_int = DIV_W'(8);
        for (int j = 0; j <= 16; j++) begin
            @(negedge clk);
            n_total++;
            if (os_tick !== (j % 8 == 0)) begin
                $display("FAIL shrink j=%0d got=%b want=%b",
                         j, os_tick, j % 8 == 0);
            end else n_pass++;
        end
        div_int = DIV_W'(1);
        repeat (3) @(negedge clk);
        n_total++;
        if (os_tick !== 1'b1) begin
            $display("FAIL div1_high got=%b want=1", os_tick);
        end else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_total++;
        if ({os_tick, mid_tick, bit_tick, cfg_err} !== 4'b0000) begin
            $display("FAIL async_reset got=%b want=0000",
                     {os_tick, mid_tick, bit_tick, cfg_err});
        end else n_pass++;
        @(negedge clk);
        div_int = DIV_W'(5);
        reset_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            n_total++;
            if (os_tick !== (e % 5 == 0)) begin
                $display("FAIL restart edge=%0d got=%b want=%b",
                         e, os_tick, e % 5 == 0);
            end else n_pass++;
        end
    endtask

    task automatic test_random;
        int errs;
        errs = 0;
        for (int round = 0; round < 8; round++) begin
            @(negedge clk);
            div_int = DIV_W'($urandom_range(1, 12));
            div_frac = FRAC_W'($urandom);
            osr = (round == 0) ? '0 : OSR_W'($urandom);
            resync = 1'b1;
            enable = 1'b1;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                n_total++;
                if ({os_tick, mid_tick, bit_tick, cfg_err}
                    !== {e_os, e_mid, e_bit, e_err}) begin
                    if (errs < 10)
                        $display("FAIL random r=%0d c=%0d got=%b want=%b",
                                 round, c,
                                 {os_tick, mid_tick, bit_tick, cfg_err},
                                 {e_os, e_mid, e_bit, e_err});
                    errs++;
                end else n_pass++;
                enable = ($urandom_range(0, 3) != 0);
                resync = ($urandom_range(0, 59) == 0);
            end
        end
        resync = 1'b0;
    endtask

    initial begin
        test_reset;
        test_integer;
        test_fractional;
        test_resync;
        test_enable;
        test_illegal;
        test_shrink_reset;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
